// File: rtl/imm_split_if.sv
// Stream bundle for imm_split: 32-bit constant input channel and
// 16-bit immediate output channel, both valid/ready.
interface imm_split_if;
  logic        in_valid_i;
  logic [31:0] in_data_i;
  logic        in_ready_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_imm_o;
  logic [1:0]  out_kind_o;
  logic        out_last_o;

  // Encoder side
  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_imm_o, out_kind_o, out_last_o
  );

  // Producer/consumer side
  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_imm_o, out_kind_o, out_last_o
  );
endinterface

// File: rtl/imm_split.sv
// imm_split: encodes each 32-bit constant as the shortest sequence of
// 16-bit immediates (SEXT, or LUI+ORI pair) that the CPU extend units
// rebuild exactly. Defining IMM_SPLIT_SHORT_EN adds the single-beat
// ZEXT (upper half zero) and LUI-only (lower half zero) forms.
module imm_split (
  input  logic        clk_i,
  input  logic        rst_i,
  imm_split_if.slave  bus
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FIRST
  } state_t;

  typedef enum logic [1:0] {
    K_SEXT = 2'b00,
    K_ZEXT = 2'b01,
    K_LUI  = 2'b10,
    K_ORI  = 2'b11
  } kind_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [15:0] imm_q, imm_d;
  kind_t       kind_q, kind_d;
  logic        last_q, last_d;
  logic [15:0] lo_q, lo_d;

  logic        in_ready;
  logic        in_xfer;
  logic        out_xfer;

  logic        is_sext;
  logic        is_zext;
  logic        is_luio;

  // Classify the incoming word; only feeds registers, never outputs.
  always_comb begin
    is_sext = (bus.in_data_i[31:15] == '0) || (bus.in_data_i[31:15] == '1);
`ifdef IMM_SPLIT_SHORT_EN
    is_zext = !is_sext && (bus.in_data_i[31:16] == '0);
    is_luio = !is_sext && !is_zext && (bus.in_data_i[15:0] == '0);
`else
    is_zext = 1'b0;
    is_luio = 1'b0;
`endif
  end

  // Input acceptance: free when empty, follows the consumer when the
  // held beat is final, blocked while a pair's LUI beat is pending.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_EMPTY: in_ready = 1'b1;
      S_ONE:   in_ready = bus.out_ready_i;
      default: in_ready = 1'b0;
    endcase
    in_xfer  = bus.in_valid_i && in_ready;
    out_xfer = valid_q && bus.out_ready_i;
  end

  // Next-state and next-beat selection; output registers hold by default.
  always_comb begin
    state_d = state_q;
    imm_d   = imm_q;
    kind_d  = kind_q;
    last_d  = last_q;
    lo_d    = lo_q;
    // An input transfer can only happen when no beat is held or the held
    // final beat is leaving this cycle, so it always loads a fresh beat.
    if (in_xfer) begin
      if (is_sext) begin
        state_d = S_ONE;
        kind_d  = K_SEXT;
        imm_d   = bus.in_data_i[15:0];
        last_d  = 1'b1;
      end else if (is_zext) begin
        state_d = S_ONE;
        kind_d  = K_ZEXT;
        imm_d   = bus.in_data_i[15:0];
        last_d  = 1'b1;
      end else if (is_luio) begin
        state_d = S_ONE;
        kind_d  = K_LUI;
        imm_d   = bus.in_data_i[31:16];
        last_d  = 1'b1;
      end else begin
        state_d = S_FIRST;
        kind_d  = K_LUI;
        imm_d   = bus.in_data_i[31:16];
        last_d  = 1'b0;
        lo_d    = bus.in_data_i[15:0];
      end
    end else if (out_xfer) begin
      case (state_q)
        S_FIRST: begin
          state_d = S_ONE;
          kind_d  = K_ORI;
          imm_d   = lo_q;
          last_d  = 1'b1;
        end
        S_ONE:   state_d = S_EMPTY;
        default: state_d = state_q;
      endcase
    end
    valid_d = (state_d != S_EMPTY);
  end

  // State and output beat registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
      valid_q <= 1'b0;
      imm_q   <= '0;
      kind_q  <= K_SEXT;
      last_q  <= 1'b0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      imm_q   <= imm_d;
      kind_q  <= kind_d;
      last_q  <= last_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = valid_q;
  assign bus.out_imm_o   = imm_q;
  assign bus.out_kind_o  = kind_q;
  assign bus.out_last_o  = last_q;

endmodule

// File: tb/tb_imm_split.sv
// Scoreboard bench for imm_split. Stimulus pushes hand-computed beats and
// the accepted words; a negedge monitor pops/compares beats and rebuilds
// each constant from its beat sequence.
module tb_imm_split;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] imm;
    logic        last;
  } beat_t;

  logic clk;
  logic rst;
  imm_split_if bus ();

  imm_split dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t       beat_q[$];
  logic [31:0] word_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_in   = 0;
  int          n_last = 0;
  logic [31:0] acc    = '0;
  logic        rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic exp_beat(input logic [1:0] k, input logic [15:0] i, input logic l);
    beat_t b;
    b.kind = k;
    b.imm  = i;
    b.last = l;
    beat_q.push_back(b);
  endtask

  // Present one word; returns the number of cycles it waited for in_ready.
  task automatic send(input logic [31:0] w, output int stalls);
    bit done;
    stalls = 0;
    done   = 0;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = w;
    for (int c = 0; c < 100 && !done; c++) begin
      if (rand_rdy) bus.out_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.in_ready_o) begin
        word_q.push_back(w);
        n_in++;
        done = 1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid_i = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    bus.out_ready_i = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk);
      #1;
      if (word_q.size() == 0 && !bus.out_valid_o) done = 1;
    end
    if (!done) chk("drain_timeout", word_q.size(), 32'd0);
  endtask

  // Monitor: compare each output transfer against the scoreboard.
  always @(negedge clk) begin
    beat_t got;
    beat_t e;
    logic [31:0] nxt;
    if (!rst && bus.out_valid_o && bus.out_ready_i) begin
      got.kind = bus.out_kind_o;
      got.imm  = bus.out_imm_o;
      got.last = bus.out_last_o;
      if (beat_q.size() > 0) begin
        e = beat_q.pop_front();
        chk("beat{kind,imm,last}", {13'd0, got}, {13'd0, e});
      end
`ifndef IMM_SPLIT_SHORT_EN
      chk("no_zext_kind", {31'd0, got.kind == 2'b01}, 32'd0);
`endif
      case (got.kind)
        2'b00:   nxt = {{16{got.imm[15]}}, got.imm};
        2'b01:   nxt = {16'h0000, got.imm};
        2'b10:   nxt = {got.imm, 16'h0000};
        default: nxt = acc | {16'h0000, got.imm};
      endcase
      acc = nxt;
      if (got.last) begin
        n_last++;
        if (word_q.size() == 0) begin
          chk("unexpected_beat", nxt, 32'hxxxxxxxx);
        end else begin
          chk("closure", nxt, word_q.pop_front());
        end
      end
    end
  end

  initial begin
    int st;
    logic [31:0] w;
    rst = 1'b1;
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = '0;
    bus.out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs{valid,kind,imm,last}",
        {12'd0, bus.out_valid_o, bus.out_kind_o, bus.out_imm_o, bus.out_last_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, bus.in_ready_o}, 32'd1);

    // Sign-extended extremes, one per cycle
    exp_beat(2'b00, 16'h7FFF, 1'b1);
    exp_beat(2'b00, 16'h8000, 1'b1);
    exp_beat(2'b00, 16'hFFFF, 1'b1);
    send(32'h00007FFF, st); chk("sext0_stall", st, 0);
    send(32'hFFFF8000, st); chk("sext1_stall", st, 0);
    send(32'hFFFFFFFF, st); chk("sext2_stall", st, 0);
    drain();

    // Short forms
`ifdef IMM_SPLIT_SHORT_EN
    exp_beat(2'b01, 16'h8000, 1'b1);
    exp_beat(2'b10, 16'h1234, 1'b1);
`else
    exp_beat(2'b10, 16'h0000, 1'b0);
    exp_beat(2'b11, 16'h8000, 1'b1);
    exp_beat(2'b10, 16'h1234, 1'b0);
    exp_beat(2'b11, 16'h0000, 1'b1);
`endif
    send(32'h00008000, st);
    send(32'h12340000, st);
    drain();

    // Pair with next word queued behind it
    exp_beat(2'b10, 16'h1234, 1'b0);
    exp_beat(2'b11, 16'h5678, 1'b1);
    exp_beat(2'b00, 16'h0001, 1'b1);
    send(32'h12345678, st);
    chk("pair_in_ready_lui", {31'd0, bus.in_ready_o}, 32'd0);
    send(32'h00000001, st);
    chk("pair_second_stall", st, 1);
    drain();

    // Backpressure on a held LUI beat
    bus.out_ready_i = 1'b0;
    exp_beat(2'b10, 16'h1234, 1'b0);
    exp_beat(2'b11, 16'h5678, 1'b1);
    send(32'h12345678, st);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold{valid,kind,imm,last,in_ready}",
          {11'd0, bus.out_valid_o, bus.out_kind_o, bus.out_imm_o, bus.out_last_o, bus.in_ready_o},
          {11'd0, 1'b1, 2'b10, 16'h1234, 1'b0, 1'b0});
    end
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_ori{kind,imm,last}",
        {13'd0, bus.out_kind_o, bus.out_imm_o, bus.out_last_o}, {13'd0, 2'b11, 16'h5678, 1'b1});
    drain();

    // Reset while the ORI half is pending
    bus.out_ready_i = 1'b0;
    send(32'hCAFE1234, st);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_outs{valid,kind,imm,last}",
        {12'd0, bus.out_valid_o, bus.out_kind_o, bus.out_imm_o, bus.out_last_o}, 32'd0);
    n_in -= word_q.size();
    word_q.delete();
    beat_q.delete();
    acc = '0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rel_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_rel_no_beat", {31'd0, bus.out_valid_o}, 32'd0);
    end

    // Random closure with random consumer backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      case ($urandom_range(0, 3))
        0: w = $urandom();
        1: begin w[15:0] = $urandom_range(0, 65535); w[31:16] = {16{w[15]}}; end
        2: w = {16'h0000, 16'($urandom_range(0, 65535))};
        default: w = {16'($urandom_range(0, 65535)), 16'h0000};
      endcase
      send(w, st);
    end
    rand_rdy = 1'b0;
    drain();

    chk("last_count_vs_inputs", n_last, n_in);
    chk("scoreboard_empty", beat_q.size() + word_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_split.md
# imm_split

Immediate encoder for the single-cycle CPU toolchain path: the inverse of the 16→32 sign-extension performed in the datapath. It accepts a stream of 32-bit constants over a valid/ready handshake. Each constant is emitted as the minimal sequence of 16-bit instruction immediates: a single sign-extended immediate, or an upper/lower pair (`lui` / `ori`). It sits between the constant/program loader and the instruction-word builder, so that every emitted immediate reproduces the original constant exactly when passed back through the CPU's extend units.

## Interface
Parameters:
- none; widths are fixed at 32-bit input and 16-bit immediate.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `in_valid_i`  in  1  `in_data_i` holds a constant.
- `in_data_i`  in  32  constant to encode.
- `in_ready_o`  out  1  block accepts the input this cycle. Combinational from state and `out_ready_i`.
- `out_valid_o`  out  1  the output beat is valid.
- `out_ready_i`  in  1  the consumer takes the beat this cycle.
- `out_imm_o`  out  16  immediate field.
- `out_kind_o`  out  2  encoding of the beat: 00 SEXT (`addi`-style), 01 ZEXT (`ori` from `$0`), 10 LUI, 11 ORI.
- `out_last_o`  out  1  final beat of the current constant.

## Operation
- Transfers:
  - Input transfer = `in_valid_i & in_ready_o`.
  - Output transfer = `out_valid_o & out_ready_i`.
- Classification of an accepted word `d`:
  - **SEXT.** `d[31:15]` all equal. Emit one beat: SEXT, `d[15:0]`, last=1.
  - **ZEXT.** `d[31:16]==0` and SEXT does not apply (macro only). Emit one beat: ZEXT, `d[15:0]`, last=1.
  - **LUI-only.** `d[15:0]==0` and SEXT does not apply (macro only). Emit one beat: LUI, `d[31:16]`, last=1.
  - **Otherwise.** Emit two beats: LUI `d[31:16]` with last=0, then ORI `d[15:0]` with last=1.
- Classification priority is SEXT > ZEXT > LUI-only > pair. 0x00000000 is therefore SEXT.
- State machine:
  - `S_EMPTY`: no beat held.
  - `S_ONE`: final beat held.
  - `S_FIRST`: LUI beat held; the low half is stored in `lo_q`.
- Transitions:
  - `S_EMPTY`: input transfer → `S_ONE` (single-beat class) or `S_FIRST` (pair).
  - `S_ONE` with output transfer and input transfer → `S_ONE` or `S_FIRST` per the new word.
  - `S_ONE` with output transfer and no input transfer → `S_EMPTY`.
  - `S_FIRST` with output transfer → `S_ONE`; the output loads ORI, `lo_q`, last=1.
  - Any state without an output transfer holds.
- `in_ready_o`:
  - 1 in `S_EMPTY`.
  - Equals `out_ready_i` in `S_ONE`.
  - 0 in `S_FIRST`.
  - No input is ever accepted while a pair's first beat is pending.
- Output stability: while `out_valid_o=1` and `out_ready_i=0`, `out_imm_o`, `out_kind_o` and `out_last_o` hold unchanged.
- `out_valid_o` = (state != `S_EMPTY`), driven from a register.
- Reset behaviour:
  - State → `S_EMPTY`.
  - `out_valid_o`=0, `out_imm_o`=0, `out_kind_o`=00, `out_last_o`=0, `lo_q`=0.
  - `in_ready_o`=1 once reset deasserts.
  - Reset asserted mid-pair discards the pending ORI beat. No partial beat appears after release.
- Decode closure: for every emitted sequence, sign-extend (SEXT), zero-extend (ZEXT), `imm<<16` (LUI) and OR of the low half (ORI) reproduce `d` exactly.

## Timing
- Latency: an input accepted at edge N appears on the outputs after edge N (valid in cycle N+1).
- Throughput:
  - Single-beat constants: 1 per cycle under continuous `out_ready_i=1`.
  - Pair constants: 1 per 2 cycles. `in_ready_o` is low during the LUI cycle.
- Simultaneous output and input transfer in `S_ONE` is supported with no bubble.
- No combinational path from `in_valid_i` or `in_data_i` to any output. The only combinational output path is `out_ready_i` → `in_ready_o`.

## Configuration
- `IMM_SPLIT_SHORT_EN` defined:
  - ZEXT and LUI-only single-beat forms are enabled.
  - `out_kind_o` may take value 01.
- Not defined:
  - Every word that fails the SEXT test is emitted as a LUI+ORI pair, including words with a zero upper or zero lower half.
  - `out_kind_o` never equals 01.
  - Classification logic for the short forms is absent.

## Test plan
- **Sign-extended extremes.** Inputs 0x00007FFF, 0xFFFF8000 and 0xFFFFFFFF back-to-back with `out_ready_i=1`.
  - Beats: SEXT 0x7FFF, SEXT 0x8000, SEXT 0xFFFF, each last=1.
  - One beat per cycle; `in_ready_o` stays 1.
- **Short forms.** Inputs 0x00008000, then 0x12340000.
  - With the macro: ZEXT 0x8000 last=1, then LUI 0x1234 last=1.
  - Without the macro: LUI 0x0000/ORI 0x8000, then LUI 0x1234/ORI 0x0000.
- **Pair with input held.** Input 0x12345678 with `in_valid_i` held high and a second word 0x00000001 queued.
  - Beats: LUI 0x1234 last=0, then ORI 0x5678 last=1, then SEXT 0x0001.
  - `in_ready_o`=0 during the LUI cycle.
- **Backpressure.** `out_ready_i=0` for 5 cycles while a LUI beat is held.
  - Outputs stay constant; `in_ready_o`=0.
  - Releasing `out_ready_i` yields ORI 0x5678 on the next cycle.
- **Reset mid-pair.** Assert `rst_i` asynchronously while in `S_FIRST`.
  - `out_valid_o` drops immediately; all outputs go to their reset values.
  - After release: `in_ready_o`=1, and no ORI beat is emitted.
- **Random closure.** 10k random words with random `out_ready_i`.
  - Reconstruction of each output sequence equals the input word.
  - `out_last_o` count equals the input-transfer count.
